// File: rtl/e2_s2p_pkg.sv
// rtl/e2_s2p_pkg.sv - shared types and helpers for the e2 serial/parallel packers
package e2_pkg;

   localparam int SEQ_CNT_MAX_DFLT    = 5;
   localparam int APP_DATA_WIDTH_DFLT = 64;
   localparam int CNT_W_DFLT          = $clog2(SEQ_CNT_MAX_DFLT + 1);

   // One assembled frame at the default geometry; parametrised users build
   // the same layout with their own widths.
   typedef struct packed {
      logic [SEQ_CNT_MAX_DFLT*APP_DATA_WIDTH_DFLT-1:0] data;
      logic [SEQ_CNT_MAX_DFLT-1:0]                     keep;
      logic [CNT_W_DFLT-1:0]                           cnt;
   } frame_t;

   // A length of zero or above the maximum means "use the full frame".
   function automatic int clamp_len(input int len, input int max_len);
      if (len == 0 || len > max_len) begin
         return max_len;
      end
      return len;
   endfunction

endpackage

// File: rtl/e2_s2p_if.sv
// rtl/e2_s2p_if.sv - serial input / parallel output bundle of the e2 packer
interface e2_s2p_if
   import e2_pkg::*;
#(
   parameter int SEQ_CNT_MAX    = SEQ_CNT_MAX_DFLT,
   parameter int APP_DATA_WIDTH = APP_DATA_WIDTH_DFLT
) ();

   localparam int CNT_W = $clog2(SEQ_CNT_MAX + 1);

   logic [CNT_W-1:0]                      cfg_len;
   logic                                  seq_valid;
   logic                                  seq_ready;
   logic [APP_DATA_WIDTH-1:0]             seq;
   logic                                  seq_last;
   logic [APP_DATA_WIDTH*SEQ_CNT_MAX-1:0] par;
   logic [SEQ_CNT_MAX-1:0]                par_keep;
   logic [CNT_W-1:0]                      par_cnt;
   logic                                  par_valid;
   logic                                  par_ready;

   // Packer side.
   modport slave (
      input  cfg_len, seq_valid, seq, seq_last, par_ready,
      output seq_ready, par, par_keep, par_cnt, par_valid
   );

   // Upstream producer / downstream consumer side.
   modport master (
      output cfg_len, seq_valid, seq, seq_last, par_ready,
      input  seq_ready, par, par_keep, par_cnt, par_valid
   );

endinterface

// File: rtl/e2_s2p_outreg.sv
// rtl/e2_s2p_outreg.sv - single-entry valid/ready holding register
module e2_s2p_outreg
   import e2_pkg::*;
#(
   parameter type T = frame_t
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  T     in_data,
   output logic out_valid,
   input  logic out_ready,
   output T     out_data
);

   // Free when empty or when the held entry leaves on this edge.
   assign in_ready = !out_valid || out_ready;

   // Load a new entry, drop the drained one, otherwise hold steady.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/e2_s2p.sv
// rtl/e2_s2p.sv - runtime-length serial-to-parallel packer with valid/ready on both sides
module e2_s2p
   import e2_pkg::*;
#(
   parameter int SEQ_CNT_MAX    = SEQ_CNT_MAX_DFLT,
   parameter int APP_DATA_WIDTH = APP_DATA_WIDTH_DFLT,
   parameter int CNT_W          = $clog2(SEQ_CNT_MAX + 1)
) (
   input  logic     clk,
   input  logic     rst,
   e2_s2p_if.slave  bus
);

   localparam int PW = SEQ_CNT_MAX * APP_DATA_WIDTH;

   typedef struct packed {
      logic [PW-1:0]          data;
      logic [SEQ_CNT_MAX-1:0] keep;
      logic [CNT_W-1:0]       cnt;
   } frame_s_t;

   // Slices [0, n) are valid.
   function automatic logic [SEQ_CNT_MAX-1:0] keep_of(input logic [CNT_W-1:0] n);
      logic [SEQ_CNT_MAX-1:0] k;
      for (int i = 0; i < SEQ_CNT_MAX; i++) begin
         k[i] = (CNT_W'(i) < n);
      end
      return k;
   endfunction

   logic [PW-1:0]    asm_data;
   logic [CNT_W-1:0] asm_cnt;
   logic [CNT_W-1:0] len_q;
   logic             done_q;

   logic [CNT_W-1:0] len_clamped;
   logic [CNT_W-1:0] eff_len;
   logic             accept;
   logic             closing;
   logic [PW-1:0]    nxt_data;
   logic [CNT_W-1:0] nxt_cnt;
   frame_s_t         nxt_frame;
   frame_s_t         done_frame;
   frame_s_t         load_frame;
   logic             load_valid;
   logic             load_ready;
   frame_s_t         out_frame;
   logic             out_valid;

   // A finished frame parked in assembly blocks further input until it moves out.
   assign bus.seq_ready = !done_q;
   assign accept        = bus.seq_valid && !done_q;

   // The first word of a frame uses the live cfg_len; later words use the latched one.
   assign len_clamped = CNT_W'(clamp_len(int'(bus.cfg_len), SEQ_CNT_MAX));
   assign eff_len     = (asm_cnt == '0) ? len_clamped : len_q;
   assign closing     = accept && (bus.seq_last || (asm_cnt == eff_len - CNT_W'(1)));

   // Assembly contents after writing the incoming word into slice asm_cnt;
   // a new frame starts from an all-zero buffer so unused slices read as 0.
   always_comb begin
      nxt_data = (asm_cnt == '0) ? '0 : asm_data;
      for (int i = 0; i < SEQ_CNT_MAX; i++) begin
         if (CNT_W'(i) == asm_cnt) begin
            nxt_data[i*APP_DATA_WIDTH +: APP_DATA_WIDTH] = bus.seq;
         end
      end
      nxt_cnt = asm_cnt + CNT_W'(1);
   end

   assign nxt_frame  = '{data: nxt_data, keep: keep_of(nxt_cnt), cnt: nxt_cnt};
   assign done_frame = '{data: asm_data, keep: keep_of(asm_cnt), cnt: asm_cnt};

   // A parked frame and a closing word never coincide since input is stalled while parked.
   assign load_valid = done_q || closing;
   assign load_frame = done_q ? done_frame : nxt_frame;

   // Assembly counter, slice writes, length latch and the parked-frame flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         asm_data <= '0;
         asm_cnt  <= '0;
         len_q    <= '0;
         done_q   <= 1'b0;
      end else if (done_q) begin
         if (load_ready) begin
            done_q   <= 1'b0;
            asm_cnt  <= '0;
            asm_data <= '0;
         end
      end else if (accept) begin
         if (asm_cnt == '0) begin
            len_q <= len_clamped;
         end
         if (closing && load_ready) begin
            asm_cnt  <= '0;
            asm_data <= '0;
         end else begin
            done_q   <= closing;
            asm_cnt  <= nxt_cnt;
            asm_data <= nxt_data;
         end
      end
   end

   e2_s2p_outreg #(
      .T (frame_s_t)
   ) u_outreg (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (load_valid),
      .in_ready  (load_ready),
      .in_data   (load_frame),
      .out_valid (out_valid),
      .out_ready (bus.par_ready),
      .out_data  (out_frame)
   );

   assign bus.par       = out_frame.data;
   assign bus.par_keep  = out_frame.keep;
   assign bus.par_cnt   = out_frame.cnt;
   assign bus.par_valid = out_valid;

endmodule

// File: tb/tb_e2_s2p.sv
// tb/tb_e2_s2p.sv - scoreboard bench for the e2 serial-to-parallel packer
module tb_e2_s2p;
   import e2_pkg::*;

   localparam int N  = 5;
   localparam int W  = 64;
   localparam int PW = N * W;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   e2_s2p_if #(.SEQ_CNT_MAX(N), .APP_DATA_WIDTH(W)) bus ();

   e2_s2p #(.SEQ_CNT_MAX(N), .APP_DATA_WIDTH(W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int emitted = 0;

   typedef struct {
      logic [PW-1:0] data;
      logic [N-1:0]  keep;
      int            cnt;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] cur_words[$];
   int           cur_len = N;

   logic          held_v = 1'b0;
   logic [PW-1:0] held_par;
   logic [N-1:0]  held_keep;
   int            held_cnt;

   task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Expected frame from the words collected so far: word i in slice i, first word at the LSB.
   function automatic exp_t make_frame();
      exp_t e;
      e.data = '0;
      foreach (cur_words[i]) e.data[i*W +: W] = cur_words[i];
      e.cnt  = cur_words.size();
      e.keep = N'((1 << e.cnt) - 1);
      return e;
   endfunction

   // Monitor (compare on output handshake, stability while stalled) and reference model.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         cur_words.delete();
         held_v = 1'b0;
      end else begin
         if (bus.par_valid) begin
            if (held_v) begin
               check("hold_par",  bus.par, held_par);
               check("hold_keep", PW'(bus.par_keep), PW'(held_keep));
               check("hold_cnt",  PW'(bus.par_cnt), PW'(held_cnt));
            end
            if (bus.par_ready) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_frame: got cnt %0d expected no frame", bus.par_cnt);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  check("par",      bus.par, e.data);
                  check("par_keep", PW'(bus.par_keep), PW'(e.keep));
                  check("par_cnt",  PW'(bus.par_cnt), PW'(e.cnt));
                  emitted++;
               end
               held_v = 1'b0;
            end else begin
               held_v    = 1'b1;
               held_par  = bus.par;
               held_keep = bus.par_keep;
               held_cnt  = int'(bus.par_cnt);
            end
         end else begin
            held_v = 1'b0;
         end

         if (bus.seq_valid && bus.seq_ready) begin
            if (cur_words.size() == 0) begin
               cur_len = (bus.cfg_len == 0 || int'(bus.cfg_len) > N) ? N : int'(bus.cfg_len);
            end
            cur_words.push_back(bus.seq);
            if (bus.seq_last || cur_words.size() == cur_len) begin
               exp_q.push_back(make_frame());
               cur_words.delete();
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.seq_valid = 1'b0;
      bus.seq_last  = 1'b0;
   endtask

   // Present one word and return just after the edge that accepts it.
   task automatic send(input logic [W-1:0] w, input logic l, output int stalls);
      logic acc;
      logic got;
      got = 1'b0;
      stalls = 0;
      bus.seq       = w;
      bus.seq_last  = l;
      bus.seq_valid = 1'b1;
      for (int c = 0; c < 200 && !got; c++) begin
         @(negedge clk);
         acc = bus.seq_ready;
         tick();
         if (acc) got = 1'b1;
         else stalls++;
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
      end
   endtask

   task automatic wait_emitted(input string name, input int target);
      for (int c = 0; c < 100 && emitted < target; c++) tick();
      check(name, PW'(emitted), PW'(target));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int st;
      int ssum;
      int e0;
      logic stop_rand;

      rst           = 1'b1;
      bus.cfg_len   = 3'd5;
      bus.seq       = '0;
      bus.seq_last  = 1'b0;
      bus.seq_valid = 1'b0;
      bus.par_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      check("rst_par_valid", PW'(bus.par_valid), PW'(0));
      check("rst_par",       bus.par, '0);
      check("rst_par_keep",  PW'(bus.par_keep), PW'(0));
      check("rst_par_cnt",   PW'(bus.par_cnt), PW'(0));
      check("rst_seq_ready", PW'(bus.seq_ready), PW'(1));

      // Full-length frame, back to back.
      bus.cfg_len = 3'd5;
      for (int k = 1; k <= 5; k++) send(W'(k), 1'b0, st);
      idle();
      check("t1_latency", PW'(bus.par_valid), PW'(1));
      check("t1_cnt",     PW'(bus.par_cnt), PW'(5));
      check("t1_keep",    PW'(bus.par_keep), PW'(5'b11111));
      tick();

      // Early termination, then a normal frame from slice 0.
      bus.cfg_len = 3'd3;
      send(64'hA, 1'b0, st);
      send(64'hB, 1'b1, st);
      check("t2_cnt",  PW'(bus.par_cnt), PW'(2));
      check("t2_keep", PW'(bus.par_keep), PW'(5'b00011));
      send(64'hC, 1'b0, st);
      send(64'hD, 1'b0, st);
      send(64'hE, 1'b0, st);
      idle();
      tick();

      // Length-1 frames at full rate.
      bus.cfg_len = 3'd1;
      e0   = emitted;
      ssum = 0;
      for (int k = 0; k < 8; k++) begin
         send(W'(64'h100 + k), 1'b0, st);
         ssum += st;
         check("t3_no_bubble", PW'(bus.par_valid), PW'(1));
      end
      idle();
      check("t3_stalls", PW'(ssum), PW'(0));
      wait_emitted("t3_count", e0 + 8);

      // Downstream stall with streaming input.
      bus.cfg_len = 3'd2;
      e0 = emitted;
      fork
         begin
            for (int k = 0; k < 6; k++) send(W'(64'h40 + k), 1'b0, st);
            idle();
         end
         begin
            bus.par_ready = 1'b0;
            repeat (10) tick();
            check("t4_seq_ready_low", PW'(bus.seq_ready), PW'(0));
            check("t4_par_valid",     PW'(bus.par_valid), PW'(1));
            bus.par_ready = 1'b1;
         end
      join
      wait_emitted("t4_count", e0 + 3);

      // Length clamping and mid-frame cfg_len change.
      e0 = emitted;
      bus.cfg_len = 3'd0;
      for (int k = 0; k < 5; k++) send(W'(64'h500 + k), 1'b0, st);
      bus.cfg_len = 3'd7;
      for (int k = 0; k < 5; k++) send(W'(64'h700 + k), 1'b0, st);
      bus.cfg_len = 3'd4;
      send(64'h900, 1'b0, st);
      bus.cfg_len = 3'd2;
      for (int k = 1; k < 4; k++) send(W'(64'h900 + k), 1'b0, st);
      idle();
      check("t5_len_latched", PW'(bus.par_cnt), PW'(4));
      wait_emitted("t5_count", e0 + 3);

      // Reset with a held output frame and a partial frame in assembly.
      bus.cfg_len   = 3'd5;
      bus.par_ready = 1'b0;
      send(64'h61, 1'b0, st);
      send(64'h62, 1'b1, st);
      send(64'h71, 1'b0, st);
      send(64'h72, 1'b0, st);
      send(64'h73, 1'b0, st);
      idle();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_par_valid", PW'(bus.par_valid), PW'(0));
      check("t6_seq_ready", PW'(bus.seq_ready), PW'(1));
      check("t6_par_cnt",   PW'(bus.par_cnt), PW'(0));
      bus.par_ready = 1'b1;
      e0 = emitted;
      for (int k = 1; k <= 5; k++) send(W'(64'h80 + k), 1'b0, st);
      idle();
      wait_emitted("t6_count", e0 + 1);

      // Randomised traffic with random backpressure and lengths.
      stop_rand = 1'b0;
      fork
         begin
            for (int k = 0; k < 400; k++) begin
               bus.cfg_len = 3'($urandom_range(0, 7));
               send({$urandom, $urandom}, ($urandom % 6) == 0, st);
               if ($urandom % 4 == 0) begin
                  idle();
                  tick();
               end
            end
            send({$urandom, $urandom}, 1'b1, st);
            idle();
            stop_rand = 1'b1;
         end
         begin
            while (!stop_rand) begin
               bus.par_ready = ($urandom % 10) < 7;
               tick();
            end
            bus.par_ready = 1'b1;
         end
      join
      for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick();
      check("drain_empty", PW'(exp_q.size()), PW'(0));
      check("drain_par_valid", PW'(bus.par_valid), PW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/e2_s2p.md
Name: e2_s2p

Overview:
- Parametrised successor to the fixed-ratio serial-to-parallel packer in the E1 ingress path.
- Assembles up to SEQ_CNT_MAX words of APP_DATA_WIDTH into one wide word and presents it to the downstream parallel compute stage.
- Frame length is runtime-programmable, frames can be terminated early by an input last flag, and both sides use valid/ready handshakes with backpressure.
- A two-stage buffer (assembly register plus output register) sustains one input word per cycle.

Parameters:
- SEQ_CNT_MAX, 5, maximum words per frame; must be >= 1.
- APP_DATA_WIDTH, 64, bits per serial word.
- CNT_W, $clog2(SEQ_CNT_MAX+1), width of the length and count fields.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- cfg_len  in  CNT_W  words per frame; sampled at frame start.
- seq_valid  in  1  input word valid.
- seq_ready  out  1  block can accept a word this cycle.
- seq  in  APP_DATA_WIDTH  input word.
- seq_last  in  1  forces the accepted word to close the frame.
- par  out  APP_DATA_WIDTH*SEQ_CNT_MAX  assembled frame.
- par_keep  out  SEQ_CNT_MAX  one bit per slice; 1 = slice holds a valid word.
- par_cnt  out  CNT_W  number of valid words in the frame.
- par_valid  out  1  output frame valid.
- par_ready  in  1  downstream accepts the frame.

Behaviour:
- Reset:
  - Clock is clk. Reset is synchronous and active-high on rst.
  - On reset: par=0, par_keep=0, par_cnt=0, par_valid=0, assembly count=0, assembly buffer cleared. seq_ready=1 from the first cycle after reset.
  - Reset asserted mid-frame discards the partial frame and any held output frame; nothing is emitted.
- Input acceptance:
  - A word is accepted when seq_valid && seq_ready.
  - The k-th accepted word of a frame (k from 0) goes to slice k, bits [k*W +: W].
  - Ordering: the first word sits at the LSB.
- Frame length:
  - Latched as len_q when a word is accepted with count==0.
  - cfg_len of 0 or greater than SEQ_CNT_MAX is clamped to SEQ_CNT_MAX.
  - Changing cfg_len mid-frame has no effect on the current frame.
- Frame close:
  - The accepted word closes the frame when count==len_q-1, or when seq_last=1. seq_last wins on the same word.
  - On close, the frame (data, keep, cnt) moves to the output register when that register is empty, or is being emptied this cycle (par_valid && par_ready). count then returns to 0.
  - If the output register is full and not draining, the closed frame stays in the assembly buffer with a done flag set, and seq_ready=0.
  - When the output register frees, the frame transfers on the next edge and seq_ready returns to 1 in the following cycle.
- Slice contents: slices not written in a frame are 0 in par, with the matching par_keep bit 0. par_keep = (1<<par_cnt)-1.
- Latency:
  - par_valid asserts on the cycle after the closing word is accepted when the output register is free.
  - Sustained throughput is 1 word/clk with par_ready held at 1, including back-to-back frames of length 1.
- Output handshake:
  - par, par_keep and par_cnt stay stable while par_valid=1 && par_ready=0.
  - par_valid deasserts the cycle after acceptance unless a new frame transfers on the same edge. In that case par_valid stays 1 with the new data.
- Simultaneous events: a close, an output drain and a new frame-start word on consecutive or the same edge must not lose or duplicate data. seq_ready is combinational from done flag, par_valid and par_ready only. It never depends on seq_valid.

Decomposition:
- Package e2_pkg:
  - typedef for the frame struct {data, keep, cnt}.
  - function clamp_len.
  - constants SEQ_CNT_MAX and APP_DATA_WIDTH defaults.
- One sub-module, e2_s2p_outreg: a single-entry valid/ready holding register for the frame struct, reused later by the p2s direction.
- Assembly counter, slice write-enables and done flag remain in the top module.

Test Plan:
- cfg_len=5, words 0x1..0x5 back-to-back, par_ready=1 -> one cycle after the 5th word: par_valid=1, par slice0=0x1 .. slice4=0x5, par_keep=5'b11111, par_cnt=5.
- cfg_len=3, seq_last asserted on the 2nd word (0xA, 0xB) -> par_cnt=2, par_keep=5'b00011, slices 2..4 = 0; the next frame starts at slice 0 with length 3.
- cfg_len=1, 8 consecutive words, par_ready=1 -> 8 consecutive par_valid cycles with no bubble, each par_cnt=1; seq_ready stays 1 throughout.
- cfg_len=2, par_ready=0 for 10 cycles, input streaming:
  - first frame held stable;
  - second frame completes into assembly, then seq_ready=0;
  - after par_ready=1, both frames are emitted in order with no loss.
- cfg_len=0 and cfg_len=7 -> both clamp to 5 words per frame. Changing cfg_len from 4 to 2 after the 1st word still yields a 4-word frame.
- Assert rst after 3 of 5 words with a frame held in the output register -> next cycle par_valid=0, seq_ready=1; the following frame starts at slice 0 and the partial data never appears.
